// File: rtl/irq_controller_if.sv
// Handshake and configuration bundle between the interrupt controller and the CPU/source side.
// The master drives requests, mask writes and ack/eoi; the slave (controller) drives the outputs.
interface irq_controller_if #(
    parameter int N_IRQ = 8
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             irq_ack;
    logic             irq_eoi;
    logic             irq_req;
    logic [2:0]       irq_vector;
    logic [N_IRQ-1:0] pending;
    logic             in_service;

    modport master (
        output irq_in,
        output mask_we,
        output mask_wdata,
        output irq_ack,
        output irq_eoi,
        input  irq_req,
        input  irq_vector,
        input  pending,
        input  in_service
    );

    modport slave (
        input  irq_in,
        input  mask_we,
        input  mask_wdata,
        input  irq_ack,
        input  irq_eoi,
        output irq_req,
        output irq_vector,
        output pending,
        output in_service
    );
endinterface

// File: rtl/irq_controller.sv
// Eight-line edge-capturing interrupt controller with mask, fixed priority and ack/eoi handshake.
// Optional IRQ_SYNC_EN inserts a two-flop synchronizer ahead of edge detection.
module irq_controller #(
    parameter int         N_IRQ    = 8,
    parameter logic [7:0] MASK_RST = 8'hFF
) (
    input  logic          clk,
    input  logic          reset,
    irq_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N_IRQ-1:0] irq_src;
    logic [N_IRQ-1:0] irq_d;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clear_vec;
    logic [2:0]       vector_q;
    logic [2:0]       vector_d;
    logic [2:0]       winner;
    logic             winner_valid;
    logic             ack_accept;
    logic             eoi_accept;

`ifdef IRQ_SYNC_EN
    // Buttons and switches may feed irq_in directly, so bring them into the clk domain first.
    logic [N_IRQ-1:0] sync_1;
    logic [N_IRQ-1:0] sync_2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= bus.irq_in;
            sync_2 <= sync_1;
        end
    end

    assign irq_src = sync_2;
`else
    assign irq_src = bus.irq_in;
`endif

    // irq_d resets low so a line already high at reset release produces one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_d <= '0;
        end else begin
            irq_d <= irq_src;
        end
    end

    assign irq_edge = irq_src & ~irq_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= MASK_RST;
        end else if (bus.mask_we) begin
            mask_q <= bus.mask_wdata;
        end
    end

    assign eligible   = pending_q & mask_q;
    assign ack_accept = (state_q == REQUEST) && bus.irq_ack;
    assign eoi_accept = (state_q == SERVICE) && bus.irq_eoi;

    // Lowest index wins: scan from the top so the last hit is the smallest set bit.
    always_comb begin
        winner_valid = 1'b0;
        winner       = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_valid = 1'b1;
                winner       = 3'(i);
            end
        end
    end

    always_comb begin
        clear_vec = '0;
        if (ack_accept) begin
            clear_vec[vector_q] = 1'b1;
        end
    end

    // A fresh edge in the same cycle as the clearing ack keeps the bit pending.
    assign pending_d = (pending_q & ~clear_vec) | irq_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            vector_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            vector_q <= vector_d;
        end
    end

    // The vector is latched only when leaving IDLE and stays frozen until the next IDLE.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        case (state_q)
            IDLE: begin
                if (winner_valid) begin
                    state_d  = REQUEST;
                    vector_d = winner;
                end
            end
            REQUEST: begin
                if (ack_accept) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi_accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.irq_req    = (state_q == REQUEST);
    assign bus.in_service = (state_q == SERVICE);
    assign bus.irq_vector = vector_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller: reset, priority, masking, merge and reset-abort cases.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
    localparam int LAT_EXTRA = 2;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    irq_controller_if #(.N_IRQ(8)) bus ();

    irq_controller #(
        .N_IRQ    (8),
        .MASK_RST (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (LAT_EXTRA) tick();
    endtask

    task automatic apply_stimulus(input logic [7:0] irq, input logic ack, input logic eoi,
                                  input logic mwe, input logic [7:0] mwd);
        bus.irq_in     = irq;
        bus.irq_ack    = ack;
        bus.irq_eoi    = eoi;
        bus.mask_we    = mwe;
        bus.mask_wdata = mwd;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [2:0] vec,
                             input logic [7:0] pend, input logic svc);
        check_output({tag, "_req"}, {7'd0, bus.irq_req}, {7'd0, req});
        check_output({tag, "_vec"}, {5'd0, bus.irq_vector}, {5'd0, vec});
        check_output({tag, "_pend"}, bus.pending, pend);
        check_output({tag, "_svc"}, {7'd0, bus.in_service}, {7'd0, svc});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state with quiet inputs
        repeat (3) tick();
        check_all("in_reset", 1'b0, 3'd0, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check_all("after_release", 1'b0, 3'd0, 8'h00, 1'b0);

        // Line held high through reset yields exactly one edge after release
        reset = 1'b0;
        apply_stimulus(8'h04, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        settle();
        check_all("held_edge", 1'b0, 3'd0, 8'h04, 1'b0);
        tick();
        check_all("held_req", 1'b1, 3'd2, 8'h04, 1'b0);
        apply_stimulus(8'h04, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("held_ack", 1'b0, 3'd2, 8'h00, 1'b1);
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        settle();
        check_all("held_done", 1'b0, 3'd2, 8'h00, 1'b0);

        // Single pulse on bit 5: two-cycle latency, then ack and eoi
        apply_stimulus(8'h20, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        check_all("b5_pend", 1'b0, 3'd2, 8'h20, 1'b0);
        tick();
        check_all("b5_req", 1'b1, 3'd5, 8'h20, 1'b0);
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("b5_eoi_ignored", 1'b1, 3'd5, 8'h20, 1'b0);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("b5_ack", 1'b0, 3'd5, 8'h00, 1'b1);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check_all("b5_ack_ignored", 1'b0, 3'd5, 8'h00, 1'b1);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("b5_eoi", 1'b0, 3'd5, 8'h00, 1'b0);
        tick();
        check_all("b5_idle", 1'b0, 3'd5, 8'h00, 1'b0);

        // Simultaneous edges on bits 6 and 1: bit 1 first, then bit 6
        apply_stimulus(8'h42, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        check_all("b61_pend", 1'b0, 3'd5, 8'h42, 1'b0);
        tick();
        check_all("b61_req1", 1'b1, 3'd1, 8'h42, 1'b0);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check_all("b61_ack1", 1'b0, 3'd1, 8'h40, 1'b1);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("b61_eoi1", 1'b0, 3'd1, 8'h40, 1'b0);
        tick();
        check_all("b61_req6", 1'b1, 3'd6, 8'h40, 1'b0);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        check_all("b61_ack6", 1'b0, 3'd6, 8'h00, 1'b1);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Masked bit 0 stays pending until the mask is reopened
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFE);
        tick();
        apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        tick();
        tick();
        check_all("mask_hold", 1'b0, 3'd6, 8'h01, 1'b0);
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("mask_open", 1'b0, 3'd6, 8'h01, 1'b0);
        tick();
        check_all("mask_req", 1'b1, 3'd0, 8'h01, 1'b0);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Bit 3: vector frozen across mask writes, coincident edge with ack keeps it pending
        apply_stimulus(8'h08, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        tick();
        check_all("b3_req", 1'b1, 3'd3, 8'h08, 1'b0);
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hF7);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF);
        check_all("b3_frozen", 1'b1, 3'd3, 8'h08, 1'b0);
        tick();
        apply_stimulus(8'h08, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        check_all("b3_merge", 1'b0, 3'd3, 8'h08, 1'b1);
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check_all("b3_eoi", 1'b0, 3'd3, 8'h08, 1'b0);
        tick();
        check_all("b3_again", 1'b1, 3'd3, 8'h08, 1'b0);
        apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset in SERVICE with 8'h30 pending clears everything at once
        apply_stimulus(8'h30, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        tick();
        check_all("rst_req4", 1'b1, 3'd4, 8'h30, 1'b0);
        apply_stimulus(8'h10, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        settle();
        check_all("rst_svc", 1'b0, 3'd4, 8'h30, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all("rst_async", 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_all("rst_discard", 1'b0, 3'd0, 8'h00, 1'b0);

`ifdef IRQ_SYNC_EN
        // Synchronized path: bit-2 pulse reaches irq_req four cycles after it is sampled
        apply_stimulus(8'h04, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        check_output("sync_early", {7'd0, bus.irq_req}, 8'h00);
        tick();
        check_all("sync_req", 1'b1, 3'd2, 8'h04, 1'b0);
`endif

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
